// File: rtl/tick_timeout_monitor_if.sv
// Transaction/tick bundle between the tick source, requester and the timeout monitor.
// master drives tick/req/ack; slave is the monitor that drives the status outputs.
interface tick_timeout_monitor_if #(
    parameter int unsigned TBITS = 4
);
    logic             tick;
    logic             req;
    logic             ack;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             tick_lost;
    logic [TBITS-1:0] tick_cnt;

    modport master (
        output tick, req, ack,
        input  busy, done, timeout, tick_lost, tick_cnt
    );

    modport slave (
        input  tick, req, ack,
        output busy, done, timeout, tick_lost, tick_cnt
    );
endinterface

// File: rtl/tick_timeout_monitor.sv
// Bounds a req/ack transaction with a tick-based timeout and flags a missing tick
// in the upstream time base.
module tick_timeout_monitor #(
    parameter int unsigned TIMEOUT_TICKS = 8,
    parameter int unsigned TBITS         = 4,
    parameter int unsigned GAP_MAX       = 22502,
    parameter int unsigned GBITS         = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    tick_timeout_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [TBITS-1:0] LAST_TICK = TBITS'(TIMEOUT_TICKS - 1);
    localparam logic [TBITS-1:0] MAX_TICKS = TBITS'(TIMEOUT_TICKS);
    localparam logic [GBITS-1:0] GAP_SAT   = GBITS'(GAP_MAX);
    localparam logic [GBITS-1:0] GAP_LAST  = GBITS'(GAP_MAX - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [TBITS-1:0] tick_cnt_q;
    logic [GBITS-1:0] gap_q;
    logic [GBITS-1:0] gap_d;
    logic             tick_lost_q;
    logic             tick_lost_d;

    // Transaction FSM; done/timeout are single-cycle pulses on WAIT->DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mon.req) begin
                        state_q    <= ST_WAIT;
                        busy_q     <= 1'b1;
                        tick_cnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    // Abort beats ack, and ack beats a same-cycle terminal tick.
                    if (!mon.req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (mon.ack) begin
                        state_q <= ST_DRAIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (mon.tick) begin
                        if (tick_cnt_q == LAST_TICK) begin
                            state_q    <= ST_DRAIN;
                            busy_q     <= 1'b0;
                            timeout_q  <= 1'b1;
                            tick_cnt_q <= MAX_TICKS;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TBITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!mon.req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Gap watchdog: saturating count of tick-free clocks, sticky loss flag.
    always_comb begin
        gap_d       = gap_q;
        tick_lost_d = tick_lost_q;
        if (mon.tick) begin
            gap_d = '0;
        end else begin
            if (gap_q != GAP_SAT) begin
                gap_d = gap_q + GBITS'(1);
            end
            if (gap_q == GAP_LAST) begin
                tick_lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q       <= '0;
            tick_lost_q <= 1'b0;
        end else begin
            gap_q       <= gap_d;
            tick_lost_q <= tick_lost_d;
        end
    end

    assign mon.busy      = busy_q;
    assign mon.done      = done_q;
    assign mon.timeout   = timeout_q;
    assign mon.tick_lost = tick_lost_q;
    assign mon.tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_tick_timeout_monitor.sv
// Self-checking bench for tick_timeout_monitor: behavioural model feeds a scoreboard
// queue every cycle, the DUT outputs are compared one clock later.
module tb_tick_timeout_monitor;

    localparam int unsigned TIMEOUT_TICKS = 3;
    localparam int unsigned TBITS         = 2;
    localparam int unsigned GAP_MAX       = 10;
    localparam int unsigned GBITS         = 4;

    typedef enum int {M_IDLE, M_WAIT, M_DRAIN} mstate_t;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             timeout;
        logic             lost;
        logic [TBITS-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tick_timeout_monitor_if #(.TBITS(TBITS)) mon_if ();

    tick_timeout_monitor #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .TBITS         (TBITS),
        .GAP_MAX       (GAP_MAX),
        .GBITS         (GBITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if.slave)
    );

    always #5 clk = ~clk;

    int      chk_cnt = 0;
    int      err_cnt = 0;
    exp_t    sb_q[$];

    // Reference model state (unbounded gap count, integer tick count).
    mstate_t m_state = M_IDLE;
    int      m_cnt   = 0;
    int      m_gap   = 0;
    bit      m_lost  = 1'b0;
    bit      m_busy  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input bit r, input bit t, input bit q, input bit a);
        exp_t e;
        bit   d  = 1'b0;
        bit   to = 1'b0;
        if (r) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_gap   = 0;
            m_lost  = 1'b0;
            m_busy  = 1'b0;
        end else begin
            case (m_state)
                M_IDLE: if (q) begin m_state = M_WAIT; m_cnt = 0; end
                M_WAIT: begin
                    if (!q)      m_state = M_IDLE;
                    else if (a) begin m_state = M_DRAIN; d = 1'b1; end
                    else if (t) begin
                        m_cnt++;
                        if (m_cnt == TIMEOUT_TICKS) begin m_state = M_DRAIN; to = 1'b1; end
                    end
                end
                M_DRAIN: if (!q) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
            m_busy = (m_state == M_WAIT);
            if (t) m_gap = 0;
            else   m_gap++;
            if (m_gap >= GAP_MAX) m_lost = 1'b1;
        end
        e.busy    = m_busy;
        e.done    = d;
        e.timeout = to;
        e.lost    = m_lost;
        e.cnt     = TBITS'(m_cnt);
        return e;
    endfunction

    // Drive one cycle of stimulus, push the prediction, then compare after the edge.
    task automatic step(input bit t, input bit q, input bit a, input bit r = 1'b0);
        exp_t e;
        @(negedge clk);
        rst        = r;
        mon_if.tick = t;
        mon_if.req  = q;
        mon_if.ack  = a;
        sb_q.push_back(model_step(r, t, q, a));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("busy",      32'(mon_if.busy),      32'(e.busy));
            check_eq("done",      32'(mon_if.done),      32'(e.done));
            check_eq("timeout",   32'(mon_if.timeout),   32'(e.timeout));
            check_eq("tick_lost", 32'(mon_if.tick_lost), 32'(e.lost));
            check_eq("tick_cnt",  32'(mon_if.tick_cnt),  32'(e.cnt));
        end
    endtask

    initial begin
        mon_if.tick = 1'b0;
        mon_if.req  = 1'b0;
        mon_if.ack  = 1'b0;

        // Reset state
        step(0, 0, 0, 1);
        step(0, 1, 1, 1);
        check_eq("rst_busy", 32'(mon_if.busy), 32'd0);
        check_eq("rst_cnt",  32'(mon_if.tick_cnt), 32'd0);

        // 1: ack without ticks -> done one cycle after ack
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1);
        check_eq("s1_done", 32'(mon_if.done), 32'd1);
        check_eq("s1_busy", 32'(mon_if.busy), 32'd0);
        step(0, 1, 0);
        check_eq("s1_done_pulse", 32'(mon_if.done), 32'd0);
        step(1, 0, 0);
        step(0, 0, 0);

        // 2: three ticks -> timeout, tick_cnt saturates at TIMEOUT_TICKS
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        check_eq("s2_cnt2", 32'(mon_if.tick_cnt), 32'd2);
        step(0, 1, 0);
        step(1, 1, 0);
        check_eq("s2_timeout", 32'(mon_if.timeout), 32'd1);
        check_eq("s2_cnt3", 32'(mon_if.tick_cnt), 32'd3);
        step(1, 1, 1);
        check_eq("s2_drain_ign", 32'(mon_if.done), 32'd0);
        step(0, 0, 0);

        // 3: ack and terminal tick together -> done wins
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        step(1, 1, 1);
        check_eq("s3_done", 32'(mon_if.done), 32'd1);
        check_eq("s3_timeout", 32'(mon_if.timeout), 32'd0);
        check_eq("s3_cnt", 32'(mon_if.tick_cnt), 32'd2);
        step(0, 0, 0);

        // 5: reset mid-WAIT, then re-entry with req still high
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0, 1);
        check_eq("s5_busy", 32'(mon_if.busy), 32'd0);
        step(0, 1, 0);
        check_eq("s5_reenter", 32'(mon_if.busy), 32'd1);
        check_eq("s5_cnt", 32'(mon_if.tick_cnt), 32'd0);

        // 6: abort in WAIT, new request accepted after one low cycle
        step(1, 1, 0);
        step(0, 0, 0);
        check_eq("s6_abort", 32'(mon_if.busy), 32'd0);
        step(0, 1, 0);
        check_eq("s6_new", 32'(mon_if.busy), 32'd1);
        step(0, 0, 0);

        // 4: periodic ticks then silence -> tick_lost after exactly GAP_MAX clocks
        step(0, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0);
            for (int j = 0; j < 4; j++) step(0, 0, 0);
        end
        step(1, 0, 0);
        for (int j = 1; j <= 9; j++) step(0, 0, 0);
        check_eq("s4_not_yet", 32'(mon_if.tick_lost), 32'd0);
        step(0, 0, 0);
        check_eq("s4_lost", 32'(mon_if.tick_lost), 32'd1);
        for (int j = 0; j < 6; j++) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check_eq("s4_sticky", 32'(mon_if.tick_lost), 32'd1);
        step(0, 0, 0, 1);
        check_eq("s4_rst_clr", 32'(mon_if.tick_lost), 32'd0);
        step(1, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
        end

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
